// File: rtl/mux_n_to_1_reg_pkg.sv
// Shared constants and helpers for the registered N:1 multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2; callers guarantee n >= 2.
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_to_1_reg_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    // Scan from farthest to nearest so the nearest requester wins the last write.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_reg.sv
// Registered N:1 mux with valid/ready handshake, fixed or round-robin select.
// Optional even-parity output when MUX_N_PARITY_EN is defined.
module mux_n_to_1_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic [SEL_W-1:0]   out_src,
    input  logic               out_ready
`ifdef MUX_N_PARITY_EN
   ,output logic               out_parity
`endif
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_src;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic             w_rr_gv;
    logic [SEL_W-1:0] w_rr_gidx;
    logic             w_fix_gv;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (r_rr_ptr),
        .grant_valid (w_rr_gv),
        .grant_idx   (w_rr_gidx)
    );

    assign w_load_en = !r_out_valid || out_ready;

    // Compare against every legal index so a sel >= N simply never matches.
    always_comb begin
        w_fix_gv = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) w_fix_gv = 1'b1;
        end
    end

    assign w_grant_valid = (mode == MODE_RR) ? w_rr_gv   : w_fix_gv;
    assign w_grant_idx   = (mode == MODE_RR) ? w_rr_gidx : sel;
    assign w_xfer        = rst_n && w_load_en && w_grant_valid;

    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                in_ready[i] = w_xfer;
                w_sel_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register stage: drain and reload may happen on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_load_en) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_sel_data;
                    r_out_src  <= w_grant_idx;
                end
            end
            if (w_xfer && mode == MODE_RR) begin
                r_rr_ptr <= (w_grant_idx == SEL_W'(N - 1)) ? '0 : w_grant_idx + SEL_W'(1);
            end
        end
    end

`ifdef MUX_N_PARITY_EN
    logic r_out_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_parity <= 1'b0;
        end else if (w_load_en && w_xfer) begin
            r_out_parity <= ^w_sel_data;
        end
    end

    assign out_parity = r_out_parity;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Directed bench for mux_n_to_1_reg: a 4-channel/32-bit and a 5-channel/8-bit instance.
module tb_mux_n_to_1_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: N=4, WIDTH=32
    logic [127:0] a_in_data;
    logic [3:0]   a_in_valid, a_in_ready;
    logic         a_mode, a_out_valid, a_out_ready;
    logic [1:0]   a_sel, a_out_src;
    logic [31:0]  a_out_data;
    // Instance B: N=5, WIDTH=8 (non-power-of-two, sel can exceed N-1)
    logic [39:0]  b_in_data;
    logic [4:0]   b_in_valid, b_in_ready;
    logic         b_mode, b_out_valid, b_out_ready;
    logic [2:0]   b_sel, b_out_src;
    logic [7:0]   b_out_data;
`ifdef MUX_N_PARITY_EN
    logic         a_out_parity, b_out_parity;
`endif

    mux_n_to_1_reg #(.WIDTH(32), .N(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_src(a_out_src), .out_ready(a_out_ready)
`ifdef MUX_N_PARITY_EN
       ,.out_parity(a_out_parity)
`endif
    );

    mux_n_to_1_reg #(.WIDTH(8), .N(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_src(b_out_src), .out_ready(b_out_ready)
`ifdef MUX_N_PARITY_EN
       ,.out_parity(b_out_parity)
`endif
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_src;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [19];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check in_ready, clock once, check the register.
    task automatic a_row(input int id, input vec_t v);
        a_mode      = v.mode;
        a_sel       = v.sel;
        a_in_valid  = v.vld;
        a_out_ready = v.ordy;
        #1;
        chk($sformatf("a%0d.in_ready", id), 32'(a_in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("a%0d.out_valid", id), 32'(a_out_valid), 32'(v.exp_ov));
        if (v.exp_ov) begin
            chk($sformatf("a%0d.out_src", id), 32'(a_out_src), 32'(v.exp_src));
            chk($sformatf("a%0d.out_data", id), a_out_data, v.exp_data);
        end
    endtask

    task automatic b_row(input int id, input logic m, input logic [2:0] s, input logic [4:0] vld,
                         input logic [4:0] exp_rdy, input logic exp_ov,
                         input logic [2:0] exp_src, input logic [7:0] exp_data);
        b_mode      = m;
        b_sel       = s;
        b_in_valid  = vld;
        b_out_ready = 1'b1;
        #1;
        chk($sformatf("b%0d.in_ready", id), 32'(b_in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("b%0d.out_valid", id), 32'(b_out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk($sformatf("b%0d.out_src", id), 32'(b_out_src), 32'(exp_src));
            chk($sformatf("b%0d.out_data", id), 32'(b_out_data), 32'(exp_data));
        end
    endtask

    localparam logic [31:0] C0 = 32'h1111_1111;
    localparam logic [31:0] C1 = 32'h2222_2222;
    localparam logic [31:0] C2 = 32'hDEAD_BEEF;
    localparam logic [31:0] C3 = 32'h4444_4444;

    initial begin
        //          mode  sel   vld      ordy  rdy      ov    src   data
        tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, C2}; // fixed sel=2
        tbl[1]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, C1}; // back-to-back
        tbl[2]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd0, 0};  // sel invalid: drain
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, C0}; // rr from ptr 0
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, C1};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, C2};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, C3};
        tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, C0}; // wrapped, ptr -> 1
        tbl[8]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, C3}; // ptr 1 skips to 3
        tbl[9]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, C0};
        tbl[10] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, C3};
        tbl[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, C3}; // backpressure x3
        tbl[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, C3};
        tbl[13] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, C3};
        tbl[14] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, C0}; // drain+load, ptr -> 1
        tbl[15] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 0};  // no requests
        tbl[16] = '{1'b0, 2'd2, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, C2}; // empty reg loads w/o ordy
        tbl[17] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, C1}; // ptr untouched by fixed
        tbl[18] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, C1}; // stall, fixed mode

        a_in_data   = {C3, C2, C1, C0};
        b_in_data   = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        a_mode = 1'b0; a_sel = 2'd2; a_in_valid = 4'b1111;  a_out_ready = 1'b1;
        b_mode = 1'b0; b_sel = 3'd0; b_in_valid = 5'b11111; b_out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        chk("rst.a_in_ready", 32'(a_in_ready), 0);
        chk("rst.a_out_valid", 32'(a_out_valid), 0);
        chk("rst.a_out_data", a_out_data, 0);
        chk("rst.a_out_src", 32'(a_out_src), 0);
        chk("rst.b_in_ready", 32'(b_in_ready), 0);
`ifdef MUX_N_PARITY_EN
        chk("rst.a_out_parity", 32'(a_out_parity), 0);
`endif
        b_in_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) a_row(i, tbl[i]);

        // Asynchronous reset while a word is stalled in the register.
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(a_out_valid), 0);
        chk("midrst.out_data", a_out_data, 0);
        chk("midrst.out_src", 32'(a_out_src), 0);
        chk("midrst.in_ready", 32'(a_in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // rr_ptr was 2 before reset; a cleared pointer grants channel 0.
        a_row(100, '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, C0});

        b_row(0, 1'b0, 3'd4, 5'b11111, 5'b10000, 1'b1, 3'd4, 8'h14);
        b_row(1, 1'b0, 3'd5, 5'b11111, 5'b00000, 1'b0, 3'd0, 8'h00);
        b_row(2, 1'b0, 3'd7, 5'b11111, 5'b00000, 1'b0, 3'd0, 8'h00);
        b_row(3, 1'b1, 3'd0, 5'b10000, 5'b10000, 1'b1, 3'd4, 8'h14);
        b_row(4, 1'b1, 3'd0, 5'b10011, 5'b00001, 1'b1, 3'd0, 8'h10);
        b_row(5, 1'b1, 3'd0, 5'b11100, 5'b00100, 1'b1, 3'd2, 8'h12);

`ifdef MUX_N_PARITY_EN
        a_in_data[31:0] = 32'h0000_0007;
        a_row(200, '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_0007});
        chk("par.odd", 32'(a_out_parity), 1);
        a_in_data[31:0] = 32'h0000_0003;
        a_row(201, '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_0003});
        chk("par.even", 32'(a_out_parity), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_n_to_1_reg.md
Name: mux_n_to_1_reg

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Two select modes: fixed (external sel, like a plain 2:1 mux) and round-robin arbitration across requesting channels.
- Used in the datapath and data-memory path wherever several producers share one consumer, e.g. writeback sources or memory port sharing.
- One output register stage decouples input timing from the consumer.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels, 2..16.
- SEL_W, $clog2(N), width of sel and out_src.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel request.
- in_ready  out  N  per-channel accept; one-hot or zero.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_src  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async, rst_n low):
  - out_data=0, out_valid=0, out_src=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready=0 while rst_n is low.
  - An in-flight word is discarded on reset.
- Load condition: load_en = !out_valid || out_ready. The output register accepts a new word only when load_en is high.
- Grant (combinational, same cycle):
  - Fixed mode: grant channel sel if in_valid[sel] and sel < N. If sel >= N, no grant.
  - Round-robin mode: grant the first i with in_valid[i], scanning rr_ptr, rr_ptr+1, … modulo N.
- in_ready[g] = load_en && grant_valid. All other in_ready bits are 0.
- Transfer on input g (in_valid[g] && in_ready[g]):
  - Next edge: out_data <= channel g data, out_src <= g, out_valid <= 1.
  - Latency is 1 cycle from accept to out_valid.
- Output drain: on out_valid && out_ready with no new grant, out_valid <= 0 next edge.
- Simultaneous drain and load: the output register is overwritten in the same cycle. This gives full throughput of one word per cycle; no bubble is required.
- Backpressure: while out_valid && !out_ready:
  - out_data and out_src are stable.
  - All in_ready bits are 0.
- rr_ptr update:
  - Updates only on an input transfer made in round-robin mode, to (g+1) mod N. Wrap-around from N-1 goes to 0.
  - Fixed-mode transfers leave rr_ptr unchanged.
- mode and sel changes:
  - Sampled combinationally each cycle.
  - A word already in the output register is not affected.
- No requesting channel: no transfer, and the output drains normally.

Optional Feature:
- Macro: MUX_N_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit).
  - out_parity is registered alongside out_data and equals even parity (XOR reduction) of the selected input word.
  - Reset value 0.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package mux_pkg holds:
  - Constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - Function clog2 for SEL_W.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: grant_valid, grant_idx.
  - Purely combinational.
- The register stage, handshake and rr_ptr stay in the top module.

Test Plan:
- Reset mid-transfer: out_valid=1, out_ready=0, assert rst_n=0 -> out_valid=0, out_data=0 and in_ready=0 immediately, without waiting for a clock edge.
- Fixed mode, N=4, sel=2, in_valid=4'b1111, channel2=0xDEADBEEF, out_ready=1:
  - in_ready=4'b0100.
  - Next cycle out_data=0xDEADBEEF, out_src=2.
  - Then sel=5 with N=8 and channel 5 invalid -> no grant, out_valid drops.
- Round-robin, in_valid=4'b1111 held, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_valid held high.
- Round-robin, in_valid=4'b1001, rr_ptr=1 -> grant 3, then 0, then 3, showing wrap-around.
- Backpressure: out_ready=0 for 3 cycles with requests pending -> out_data stable and in_ready=0 for all 3 cycles. Raise out_ready -> the next word loads on the same edge the current one drains.
- With MUX_N_PARITY_EN defined: input 0x00000007 -> out_parity=1; input 0x00000003 -> out_parity=0.
